// File: rtl/irrigacao_controller.sv
// Irrigation sensor-path controller: debounces the 2-bit moisture level and
// sequences the pump through watering/soak with timeout and fault handling.
module irrigacao_controller #(
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_ON_CYCLES = 16,
  parameter int SOAK_CYCLES   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] U,
  input  logic       enable,
  input  logic       clear_fault,
  output logic       pump,
  output logic       fault,
  output logic [1:0] disp
);

  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int OW = (MAX_ON_CYCLES > 1) ? $clog2(MAX_ON_CYCLES) : 1;
  localparam int KW = (SOAK_CYCLES   > 1) ? $clog2(SOAK_CYCLES)   : 1;

  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [OW-1:0] ON_LAST   = OW'(MAX_ON_CYCLES - 1);
  localparam logic [KW-1:0] SOAK_LAST = KW'(SOAK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WATER,
    S_SOAK,
    S_FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      u_q, lvl_q, lvl_d;
  logic [SW-1:0]   stab_cnt_q, stab_cnt_d;
  logic [OW-1:0]   on_cnt_q, on_cnt_d;
  logic [KW-1:0]   soak_cnt_q, soak_cnt_d;

  // Debouncer: lvl only follows u_q once it has matched for STABLE_CYCLES samples.
  always_comb begin
    stab_cnt_d = stab_cnt_q;
    if (U != u_q) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != STAB_LAST) begin
      stab_cnt_d = stab_cnt_q + SW'(1);
    end
    lvl_d = (stab_cnt_q == STAB_LAST) ? u_q : lvl_q;
  end

  always_comb begin
    state_d    = state_q;
    on_cnt_d   = on_cnt_q;
    soak_cnt_d = soak_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (lvl_q == 2'b00) begin
          state_d = S_FAULT;
        end else if (enable && lvl_q == 2'b01) begin
          state_d  = S_WATER;
          on_cnt_d = '0;
        end
      end
      S_WATER: begin
        // Counter only advances while staying, so it never wraps on exit.
        if (lvl_q == 2'b00) begin
          state_d = S_FAULT;
        end else if (!enable) begin
          state_d = S_IDLE;
        end else if (lvl_q == 2'b11) begin
          state_d    = S_SOAK;
          soak_cnt_d = '0;
        end else if (on_cnt_q == ON_LAST) begin
          state_d = S_FAULT;
        end else begin
          on_cnt_d = on_cnt_q + OW'(1);
        end
      end
      S_SOAK: begin
        if (lvl_q == 2'b00) begin
          state_d = S_FAULT;
        end else if (soak_cnt_q == SOAK_LAST) begin
          state_d = S_IDLE;
        end else begin
          soak_cnt_d = soak_cnt_q + KW'(1);
        end
      end
      S_FAULT: begin
        if (clear_fault && lvl_q != 2'b00) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      u_q        <= 2'b10;
      lvl_q      <= 2'b10;
      stab_cnt_q <= '0;
      on_cnt_q   <= '0;
      soak_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      u_q        <= U;
      lvl_q      <= lvl_d;
      stab_cnt_q <= stab_cnt_d;
      on_cnt_q   <= on_cnt_d;
      soak_cnt_q <= soak_cnt_d;
    end
  end

  always_comb begin
    pump  = 1'b0;
    fault = 1'b0;
    disp  = 2'b01;
    unique case (state_q)
      S_IDLE:  disp = 2'b01;
      S_WATER: begin
        pump = 1'b1;
        disp = 2'b10;
      end
      S_SOAK:  disp = 2'b11;
      S_FAULT: begin
        fault = 1'b1;
        disp  = 2'b00;
      end
      default: disp = 2'b01;
    endcase
  end

endmodule

// File: tb/tb_irrigacao_controller.sv
// Scoreboard bench for irrigacao_controller: directed stimulus queues expected
// outputs tagged with the clock edge they must appear after.
module tb_irrigacao_controller;

  logic       clock;
  logic       reset;
  logic [1:0] U;
  logic       enable;
  logic       clear_fault;
  logic       pump;
  logic       fault;
  logic [1:0] disp;

  irrigacao_controller #(
    .STABLE_CYCLES(4),
    .MAX_ON_CYCLES(16),
    .SOAK_CYCLES(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .U(U),
    .enable(enable),
    .clear_fault(clear_fault),
    .pump(pump),
    .fault(fault),
    .disp(disp)
  );

  typedef struct {
    int         e;
    logic       p;
    logic       f;
    logic [1:0] d;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic void expect_at(input int off, input logic p, input logic f,
                                    input logic [1:0] d, input string nm);
    exp_t x;
    x.e  = cyc + off;
    x.p  = p;
    x.f  = f;
    x.d  = d;
    x.nm = nm;
    sb.push_back(x);
  endfunction

  // Monitor: compares every queued expectation due at this cycle.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].e <= cyc) begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      if (x.e < cyc) begin
        errors++;
        $display("FAIL %s stale expectation edge=%0d now=%0d", x.nm, x.e, cyc);
      end else if (pump !== x.p || fault !== x.f || disp !== x.d) begin
        errors++;
        $display("FAIL %s cyc=%0d got pump=%b fault=%b disp=%b expected pump=%b fault=%b disp=%b",
                 x.nm, cyc, pump, fault, disp, x.p, x.f, x.d);
      end
    end
  end

  initial begin
    reset       = 1'b1;
    U           = 2'b10;
    enable      = 1'b1;
    clear_fault = 1'b0;
    tick(2);
    reset = 1'b0;
    expect_at(0, 1'b0, 1'b0, 2'b01, "reset");

    // Sensor disconnect
    U = 2'b00;
    expect_at(5, 1'b0, 1'b0, 2'b01, "pre_fault");
    expect_at(6, 1'b0, 1'b1, 2'b00, "disconnect");
    tick(6);

    // clear_fault with lvl still 00 must not leave FAULT
    clear_fault = 1'b1;
    expect_at(2, 1'b0, 1'b1, 2'b00, "clr_lvl00");
    tick(2);
    U = 2'b10;
    expect_at(5, 1'b0, 1'b1, 2'b00, "fault_hold");
    expect_at(6, 1'b0, 1'b0, 2'b01, "fault_clear");
    tick(6);
    clear_fault = 1'b0;

    // Normal run: dry -> water -> wet -> soak -> idle
    U = 2'b01;
    expect_at(5, 1'b0, 1'b0, 2'b01, "run_pre");
    expect_at(6, 1'b1, 1'b0, 2'b10, "run_start");
    tick(11);
    U = 2'b11;
    expect_at(0, 1'b1, 1'b0, 2'b10, "run_mid");
    expect_at(5, 1'b1, 1'b0, 2'b10, "run_pre_wet");
    expect_at(6, 1'b0, 1'b0, 2'b11, "soak_enter");
    expect_at(13, 1'b0, 1'b0, 2'b11, "soak_last");
    expect_at(14, 1'b0, 1'b0, 2'b01, "soak_done");
    tick(14);

    // Timeout: 16 pump cycles then FAULT
    U = 2'b01;
    expect_at(5, 1'b0, 1'b0, 2'b01, "to_pre");
    expect_at(6, 1'b1, 1'b0, 2'b10, "to_start");
    expect_at(21, 1'b1, 1'b0, 2'b10, "to_last_on");
    expect_at(22, 1'b0, 1'b1, 2'b00, "timeout");
    tick(22);
    clear_fault = 1'b1;
    expect_at(1, 1'b0, 1'b0, 2'b01, "clr_idle");
    expect_at(2, 1'b1, 1'b0, 2'b10, "rewater");
    tick(2);
    clear_fault = 1'b0;

    // !enable and wet seen on the same edge: IDLE wins over SOAK
    U = 2'b11;
    tick(5);
    expect_at(0, 1'b1, 1'b0, 2'b10, "dis_pre");
    enable = 1'b0;
    expect_at(1, 1'b0, 1'b0, 2'b01, "dis_wet");
    tick(1);

    // Loss of sensor during SOAK
    enable = 1'b1;
    U = 2'b01;
    expect_at(6, 1'b1, 1'b0, 2'b10, "sk_water");
    tick(7);
    U = 2'b11;
    expect_at(6, 1'b0, 1'b0, 2'b11, "sk_soak");
    tick(6);
    U = 2'b00;
    expect_at(5, 1'b0, 1'b0, 2'b11, "sk_hold");
    expect_at(6, 1'b0, 1'b1, 2'b00, "soak_lost");
    tick(6);
    U = 2'b10;
    clear_fault = 1'b1;
    expect_at(5, 1'b0, 1'b1, 2'b00, "rec_hold");
    expect_at(6, 1'b0, 1'b0, 2'b01, "rec_idle");
    tick(6);
    clear_fault = 1'b0;

    // 3-cycle glitch is rejected
    U = 2'b01;
    expect_at(4, 1'b0, 1'b0, 2'b01, "glitch_a");
    expect_at(6, 1'b0, 1'b0, 2'b01, "glitch_b");
    expect_at(8, 1'b0, 1'b0, 2'b01, "glitch_c");
    expect_at(10, 1'b0, 1'b0, 2'b01, "glitch_d");
    expect_at(12, 1'b0, 1'b0, 2'b01, "glitch_e");
    tick(3);
    U = 2'b10;
    tick(9);

    // 4-cycle pulse is accepted and starts watering
    U = 2'b01;
    expect_at(5, 1'b0, 1'b0, 2'b01, "pulse_pre");
    expect_at(6, 1'b1, 1'b0, 2'b10, "pulse4");
    tick(4);
    U = 2'b10;
    tick(11);

    // Reset with on_cnt at 9, then a fresh run must time out after full 16
    reset = 1'b1;
    expect_at(0, 1'b1, 1'b0, 2'b10, "mr_pre");
    expect_at(1, 1'b0, 1'b0, 2'b01, "midreset");
    tick(1);
    reset = 1'b0;
    U = 2'b01;
    expect_at(5, 1'b0, 1'b0, 2'b01, "mr_idle");
    expect_at(6, 1'b1, 1'b0, 2'b10, "mr_water");
    expect_at(13, 1'b1, 1'b0, 2'b10, "mr_no_short");
    expect_at(21, 1'b1, 1'b0, 2'b10, "mr_last_on");
    expect_at(22, 1'b0, 1'b1, 2'b00, "full_timeout");
    tick(24);

    for (int i = 0; i < 5 && sb.size() > 0; i++) tick(1);
    if (sb.size() > 0) begin
      errors += sb.size();
      $display("FAIL drain %0d expectations never compared", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
